// File: rtl/thread_cmd_queue_pkg.sv
// Shared widths, command codes, FSM state codes and entry layout for the thread command queue.
package thread_cmd_queue_pkg;

    localparam int DATA_SIZE = 32;
    localparam int ADDR_SIZE = 16;

    localparam logic [3:0] THREAD_CMD_NONE = 4'h0;
    localparam logic [3:0] THREAD_CMD_RUN  = 4'h1;
    localparam logic [3:0] THREAD_CMD_STOP = 4'h2;

    localparam logic [1:0] THRD_RSLT_OK = 2'd1;

    typedef enum logic [1:0] {
        TQ_IDLE    = 2'd0,
        TQ_ISSUE   = 2'd1,
        TQ_WAIT    = 2'd2,
        TQ_BACKOFF = 2'd3
    } tq_state_t;

    typedef struct packed {
        logic [3:0]           cmd;
        logic [DATA_SIZE-1:0] data;
        logic [ADDR_SIZE-1:0] addr;
    } tq_entry_t;

    function automatic logic is_legal_cmd(input logic [3:0] cmd);
        return (cmd == THREAD_CMD_RUN) || (cmd == THREAD_CMD_STOP);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/thread_cmd_queue_fifo.sv
// Request FIFO for the thread command queue: DEPTH entries of {cmd, data, addr}, head read combinationally.
module thread_cmd_queue_fifo
    import thread_cmd_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [3:0]           i_wr_cmd,
    input  logic [DATA_SIZE-1:0] i_wr_data,
    input  logic [ADDR_SIZE-1:0] i_wr_addr,
    output logic [3:0]           o_head_cmd,
    output logic [DATA_SIZE-1:0] o_head_data,
    output logic [ADDR_SIZE-1:0] o_head_addr,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    tq_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;
    tq_entry_t     w_head;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed while the count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{cmd: i_wr_cmd, data: i_wr_data, addr: i_wr_addr};
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign o_head_cmd  = w_head.cmd;
    assign o_head_data = w_head.data;
    assign o_head_addr = w_head.addr;
    assign o_full      = (r_count == FULL_CNT);
    assign o_empty     = (r_count == '0);

endmodule

// File: rtl/thread_cmd_queue.sv
// Queues thread RUN/STOP requests, issues them one at a time to the threads manager, retries busy results.
// Optional build macro THRD_Q_STATS_EN adds saturating issue/retry/fail counters.
module thread_cmd_queue
    import thread_cmd_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int RETRY_MAX = 7,
    parameter int BACKOFF   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clk_oe,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [3:0]           i_req_cmd,
    input  logic [DATA_SIZE-1:0] i_req_data,
    input  logic [ADDR_SIZE-1:0] i_req_addr,
    output logic                 o_tm_req,
    input  logic                 i_tm_gnt,
    output logic [3:0]           o_thrd_cmd,
    output logic [DATA_SIZE-1:0] o_tm_data,
    output logic [ADDR_SIZE-1:0] o_tm_addr,
    input  logic [1:0]           i_thrd_rslt,
    output logic                 o_done_valid,
    output logic                 o_done_ok,
    output logic [3:0]           o_done_cmd
`ifdef THRD_Q_STATS_EN
    ,
    output logic [15:0]          o_stat_issued,
    output logic [15:0]          o_stat_retry,
    output logic [15:0]          o_stat_fail
`endif
);

    // state      | meaning
    // TQ_IDLE    | waiting for a head entry; illegal heads complete as failed here
    // TQ_ISSUE   | tm_req high with the head command until the manager grants
    // TQ_WAIT    | one enabled cycle after grant; samples thrd_rslt
    // TQ_BACKOFF | counting down before re-issuing the same entry

    localparam int RW = $clog2(RETRY_MAX + 1);
    localparam int BW = $clog2(BACKOFF + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX);
    localparam logic [BW-1:0] BO_INIT    = BW'(BACKOFF);

    tq_state_t            r_state;
    logic                 r_tm_req;
    logic [3:0]           r_thrd_cmd;
    logic [3:0]           r_cur_cmd;
    logic [DATA_SIZE-1:0] r_tm_data;
    logic [ADDR_SIZE-1:0] r_tm_addr;
    logic [RW-1:0]        r_retry_cnt;
    logic [BW-1:0]        r_bo_cnt;
    logic                 r_done_valid;
    logic                 r_done_ok;
    logic [3:0]           r_done_cmd;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [3:0]           w_head_cmd;
    logic [DATA_SIZE-1:0] w_head_data;
    logic [ADDR_SIZE-1:0] w_head_addr;
    logic                 w_head_legal;
    logic                 w_accepted;
    logic                 w_retry_last;
    logic                 w_illegal_done;

    assign w_push         = i_clk_oe & i_req_valid & ~w_full;
    assign w_head_legal   = is_legal_cmd(w_head_cmd);
    assign w_accepted     = (i_thrd_rslt == THRD_RSLT_OK);
    assign w_retry_last   = (r_retry_cnt == RETRY_LAST);
    assign w_illegal_done = (r_state == TQ_IDLE) & ~w_empty & ~w_head_legal;
    assign w_pop          = i_clk_oe & (w_illegal_done |
                            ((r_state == TQ_WAIT) & (w_accepted | w_retry_last)));

    thread_cmd_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_wr_cmd    (i_req_cmd),
        .i_wr_data   (i_req_data),
        .i_wr_addr   (i_req_addr),
        .o_head_cmd  (w_head_cmd),
        .o_head_data (w_head_data),
        .o_head_addr (w_head_addr),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= TQ_IDLE;
            r_tm_req     <= 1'b0;
            r_thrd_cmd   <= THREAD_CMD_NONE;
            r_cur_cmd    <= THREAD_CMD_NONE;
            r_tm_data    <= '0;
            r_tm_addr    <= '0;
            r_retry_cnt  <= '0;
            r_bo_cnt     <= '0;
            r_done_valid <= 1'b0;
            r_done_ok    <= 1'b0;
            r_done_cmd   <= THREAD_CMD_NONE;
        end else if (i_clk_oe) begin
            r_done_valid <= 1'b0;
            r_done_ok    <= 1'b0;
            r_done_cmd   <= THREAD_CMD_NONE;
            case (r_state)
                TQ_IDLE: begin
                    if (!w_empty) begin
                        if (w_head_legal) begin
                            r_tm_req    <= 1'b1;
                            r_thrd_cmd  <= w_head_cmd;
                            r_cur_cmd   <= w_head_cmd;
                            r_tm_data   <= w_head_data;
                            r_tm_addr   <= w_head_addr;
                            r_retry_cnt <= '0;
                            r_state     <= TQ_ISSUE;
                        end else begin
                            r_done_valid <= 1'b1;
                            r_done_cmd   <= w_head_cmd;
                        end
                    end
                end
                TQ_ISSUE: begin
                    if (i_tm_gnt) begin
                        r_tm_req   <= 1'b0;
                        r_thrd_cmd <= THREAD_CMD_NONE;
                        r_state    <= TQ_WAIT;
                    end
                end
                TQ_WAIT: begin
                    if (w_accepted || w_retry_last) begin
                        r_done_valid <= 1'b1;
                        r_done_ok    <= w_accepted;
                        r_done_cmd   <= r_cur_cmd;
                        r_state      <= TQ_IDLE;
                    end else begin
                        r_retry_cnt <= r_retry_cnt + RW'(1);
                        r_bo_cnt    <= BO_INIT;
                        r_state     <= TQ_BACKOFF;
                    end
                end
                TQ_BACKOFF: begin
                    r_bo_cnt <= r_bo_cnt - BW'(1);
                    if (r_bo_cnt == BW'(1)) begin
                        r_tm_req   <= 1'b1;
                        r_thrd_cmd <= r_cur_cmd;
                        r_state    <= TQ_ISSUE;
                    end
                end
                default: r_state <= TQ_IDLE;
            endcase
        end
    end

    assign o_req_ready  = ~w_full;
    assign o_tm_req     = r_tm_req;
    assign o_thrd_cmd   = r_thrd_cmd;
    assign o_tm_data    = r_tm_data;
    assign o_tm_addr    = r_tm_addr;
    assign o_done_valid = r_done_valid;
    assign o_done_ok    = r_done_ok;
    assign o_done_cmd   = r_done_cmd;

`ifdef THRD_Q_STATS_EN
    logic [15:0] r_stat_issued;
    logic [15:0] r_stat_retry;
    logic [15:0] r_stat_fail;
    logic        w_grant;
    logic        w_busy;
    logic        w_fail;

    assign w_grant = i_clk_oe & (r_state == TQ_ISSUE) & i_tm_gnt;
    assign w_busy  = i_clk_oe & (r_state == TQ_WAIT) & ~w_accepted;
    assign w_fail  = i_clk_oe & (w_illegal_done | (w_busy & w_retry_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_issued <= '0;
            r_stat_retry  <= '0;
            r_stat_fail   <= '0;
        end else begin
            if (w_grant) r_stat_issued <= sat_inc16(r_stat_issued);
            if (w_busy)  r_stat_retry  <= sat_inc16(r_stat_retry);
            if (w_fail)  r_stat_fail   <= sat_inc16(r_stat_fail);
        end
    end

    assign o_stat_issued = r_stat_issued;
    assign o_stat_retry  = r_stat_retry;
    assign o_stat_fail   = r_stat_fail;
`endif

endmodule
